// File: rtl/spi_pkg.sv
// Shared constants for the SPI mode-0 byte shifter: state encoding,
// transfer length and the saturating bit counter helper.
package spi_pkg;
  localparam int BITS_PER_XFER = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_LOAD = LOAD,
    ST_XFER = XFER,
    ST_DONE = DONE
  } state_e;

  localparam logic [3:0] CNT_MAX = 4'(BITS_PER_XFER);

  // Counter stops at a full byte so surplus SCLK rises cannot wrap it.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 4'd1;
  endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register; used once for MOSI and once for MISO.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int W = BITS_PER_XFER
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] par_o,
  output logic         ser_o
);
  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i)       sr_d = load_val_i;
    else if (shift_i) sr_d = {sr_q[W-2:0], ser_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  assign par_o = sr_q;
  assign ser_o = sr_q[W-1];
endmodule

// File: rtl/spi_shifter.sv
// SPI mode-0 master byte shifter. SCLK timing comes from an external divider
// that reports edges as one-cycle rise/fall pulses.
module spi_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = BITS_PER_XFER
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_div_ready,
  input  logic              i_sclk_rise,
  input  logic              i_sclk_fall,
  output logic              o_div_start_n,
  output logic              o_cs_n,
  output logic              o_mosi,
  input  logic              i_miso
);
  state_e            state_q;
  logic [3:0]        bit_cnt_q;
  logic              cs_n_q;
  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;

  logic              in_xfer, accept, rise_ok, fall_ok, tx_msb;
  logic [DATA_W-1:0] rx_par, tx_par_unused;
  logic              rx_ser_unused;

  assign in_xfer = (state_q == ST_XFER);
  assign accept  = (state_q == ST_IDLE) && i_tx_valid;
  // Rise wins over a coincident fall; nothing shifts once a full byte is in.
  assign rise_ok = in_xfer && i_sclk_rise && (bit_cnt_q < CNT_MAX);
  assign fall_ok = in_xfer && i_sclk_fall && !i_sclk_rise && (bit_cnt_q < CNT_MAX);

  spi_shift_reg #(.W(DATA_W)) u_tx_sr (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (accept),
    .load_val_i (i_tx_data),
    .shift_i    (fall_ok),
    .ser_i      (1'b0),
    .par_o      (tx_par_unused),
    .ser_o      (tx_msb)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx_sr (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (accept),
    .load_val_i ('0),
    .shift_i    (rise_ok),
    .ser_i      (i_miso),
    .par_o      (rx_par),
    .ser_o      (rx_ser_unused)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (i_tx_valid) begin
          state_q   <= ST_LOAD;
          cs_n_q    <= 1'b0;
          bit_cnt_q <= '0;
        end
        ST_LOAD: if (i_div_ready) state_q <= ST_XFER;
        ST_XFER: begin
          if (i_sclk_rise) bit_cnt_q <= sat_inc(bit_cnt_q);
          // Divider reports idle only after the trailing falling edge.
          if (bit_cnt_q == CNT_MAX && i_div_ready) begin
            state_q    <= ST_DONE;
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_par;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cs_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx_ready    = (state_q == ST_IDLE);
  assign o_div_start_n = !((state_q == ST_LOAD) && i_div_ready);
  assign o_cs_n        = cs_n_q;
  assign o_mosi        = tx_msb && ((state_q == ST_LOAD) || in_xfer);
  assign o_rx_valid    = rx_valid_q;
  assign o_rx_data     = rx_data_q;
endmodule

// File: tb/tb_spi_shifter.sv
// Bench for spi_shifter: behavioural SCLK divider plus MISO slave, a per-cycle
// scoreboard of received bytes, and directed scenarios with literal expectations.
module tb_spi_shifter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       dv_ready = 1'b1;
  logic       hold_nready = 1'b0;
  logic       div_ready;
  logic       sclk_rise = 1'b0, sclk_fall = 1'b0;
  logic       div_start_n, cs_n, mosi;
  logic       miso = 1'b0;

  int checks = 0, errors = 0, strobes = 0, rises = 0;
  logic [7:0] exp_q[$];
  bit         mosi_q[$];
  logic [7:0] exp_last = 8'h00, miso_byte = 8'h00, cur_mb = 8'h00;
  logic       rst_smp = 1'b0, prev_valid = 1'b0;
  bit         dv_busy = 0, pend = 0, inj_rise = 0;
  int         dv_half = 1, dv_extra = 0, dv_cnt = 0, dv_k = 0;

  assign div_ready = dv_ready & ~hold_nready;

  spi_shifter #(.DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .i_div_ready(div_ready), .i_sclk_rise(sclk_rise), .i_sclk_fall(sclk_fall),
    .o_div_start_n(div_start_n), .o_cs_n(cs_n), .o_mosi(mosi), .i_miso(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_smp <= rst_n;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mbyte(input int off);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) if (off + i < mosi_q.size()) r = {r[6:0], 1'(mosi_q[off+i])};
    return r;
  endfunction

  // Divider + slave: 16 alternating edges (rise first) spaced dv_half cycles,
  // optional surplus rises, then ready. Slave presents MISO MSB first at each rise.
  initial begin
    forever begin
      @(negedge clk);
      sclk_rise = 1'b0; sclk_fall = 1'b0;
      if (!rst_n) begin
        dv_busy = 0; pend = 0; dv_ready = 1'b1;
      end else if (dv_busy) begin
        if (dv_k == 16 + dv_extra) begin
          dv_busy = 0; dv_ready = 1'b1; exp_q.push_back(cur_mb);
        end else begin
          dv_cnt++;
          if (dv_cnt == dv_half) begin
            dv_cnt = 0;
            if (dv_k >= 16) sclk_rise = 1'b1;
            else if (dv_k % 2 == 0) begin
              sclk_rise = 1'b1; miso = cur_mb[7 - dv_k/2];
              mosi_q.push_back(mosi); rises++;
            end else sclk_fall = 1'b1;
            dv_k++;
          end
        end
      end else if (pend) begin
        pend = 0; dv_busy = 1; dv_ready = 1'b0; dv_cnt = 0; dv_k = 0; cur_mb = miso_byte;
      end else if (!div_start_n) pend = 1;
      if (inj_rise) begin sclk_rise = 1'b1; inj_rise = 0; end
    end
  end

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    if (!rst_smp) begin
      chk("rst_cs_n", cs_n, 1); chk("rst_ready", tx_ready, 1);
      chk("rst_valid", rx_valid, 0); chk("rst_rx_data", rx_data, 0);
      chk("rst_mosi", mosi, 0); chk("rst_start_n", div_start_n, 1);
      exp_last = 8'h00; exp_q.delete();
    end else begin
      chk("ready_iff_deselected", tx_ready, cs_n);
      if (dv_busy) chk("cs_low_while_clocking", cs_n, 0);
      if (!div_start_n) chk("start_only_selected", cs_n, 0);
      if (rx_valid) begin
        chk("strobe_expected", exp_q.size() > 0, 1);
        chk("strobe_one_cycle", prev_valid, 0);
        if (exp_q.size() > 0) begin
          chk("rx_data", rx_data, exp_q[0]);
          exp_last = exp_q.pop_front();
        end
        strobes++;
      end else chk("rx_data_hold", rx_data, exp_last);
    end
    prev_valid = rx_valid;
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!tx_ready && t < 5000) begin @(negedge clk); t++; end
    chk("timeout_ready", t < 5000, 1);
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] mb, output int lowc);
    int t = 0;
    miso_byte = mb;
    wait_ready();
    tx_valid = 1'b1; tx_data = tx;
    @(negedge clk);
    tx_valid = 1'b0;
    lowc = 0;
    while (cs_n == 1'b0 && t < 6000) begin lowc++; @(negedge clk); t++; end
    chk("timeout_xfer", t < 6000, 1);
  endtask

  initial begin
    int low, low2, base, t, gap, starts, r0;
    repeat (3) @(negedge clk);
    chk("reset_ready", tx_ready, 1);
    chk("reset_cs_n", cs_n, 1);
    rst_n = 1'b1;

    // Scenario 1: 0xA5 out, 0x3C back, fastest divisor.
    mosi_q.delete(); base = strobes; dv_half = 1;
    run_xfer(8'hA5, 8'h3C, low);
    chk("s1_mosi", mbyte(0), 8'hA5);
    chk("s1_nbits", mosi_q.size(), 8);
    chk("s1_rx", rx_data, 8'h3C);
    chk("s1_strobes", strobes - base, 1);
    chk("s1_cs_low", low, 20);

    // Scenario 2: divider busy for 10 cycles after accept.
    hold_nready = 1'b1; miso_byte = 8'h81; base = strobes;
    wait_ready();
    tx_valid = 1'b1; tx_data = 8'h5A;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (10) begin
      chk("s2_start_n", div_start_n, 1);
      chk("s2_cs_n", cs_n, 0);
      chk("s2_ready", tx_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 hold_nready = 1'b0;
    starts = 0; t = 0;
    @(negedge clk);
    while (cs_n == 1'b0 && t < 6000) begin
      if (!div_start_n) starts++;
      @(negedge clk); t++;
    end
    chk("s2_timeout", t < 6000, 1);
    chk("s2_starts", starts, 1);
    chk("s2_rx", rx_data, 8'h81);
    chk("s2_strobes", strobes - base, 1);

    // Scenario 3: valid held high across two bytes.
    mosi_q.delete(); base = strobes; miso_byte = 8'h11;
    wait_ready();
    tx_data = 8'h01; tx_valid = 1'b1;
    t = 0;
    while (!dv_busy && t < 100) begin @(posedge clk); t++; end
    #1 tx_data = 8'h80; miso_byte = 8'h22;
    t = 0;
    while (strobes != base + 1 && t < 500) begin @(posedge clk); t++; end
    chk("s3_timeout1", t < 500, 1);
    gap = 0; t = 0;
    @(negedge clk);
    while (cs_n == 1'b1 && t < 20) begin gap++; @(negedge clk); t++; end
    tx_valid = 1'b0;
    t = 0;
    while (strobes != base + 2 && t < 500) begin @(posedge clk); t++; end
    chk("s3_timeout2", t < 500, 1);
    chk("s3_gap", gap, 1);
    chk("s3_strobes", strobes - base, 2);
    chk("s3_mosi0", mbyte(0), 8'h01);
    chk("s3_mosi1", mbyte(8), 8'h80);
    chk("s3_rx", rx_data, 8'h22);

    // Scenario 4: reset after the 4th rise of 0xFF.
    mosi_q.delete(); base = strobes; miso_byte = 8'hAA; r0 = rises;
    wait_ready();
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    t = 0;
    while (rises < r0 + 4 && t < 200) begin @(posedge clk); t++; end
    chk("s4_timeout", t < 200, 1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("s4_cs_n", cs_n, 1);
    chk("s4_no_valid", rx_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("s4_ready", tx_ready, 1);
    chk("s4_strobes", strobes - base, 0);
    chk("s4_rx", rx_data, 8'h00);
    chk("s4_mosi4", mbyte(0), 8'h0F);

    // Scenario 5: spurious rises in IDLE and after the 8th rise.
    base = strobes; dv_half = 2;
    @(posedge clk); #1 inj_rise = 1;
    repeat (4) @(negedge clk);
    chk("s5_idle_rx", rx_data, 8'h00);
    chk("s5_idle_strobes", strobes - base, 0);
    mosi_q.delete(); dv_extra = 2;
    run_xfer(8'h3C, 8'hC3, low);
    dv_extra = 0;
    chk("s5_rx", rx_data, 8'hC3);
    chk("s5_mosi", mbyte(0), 8'h3C);
    chk("s5_strobes", strobes - base, 1);
    @(posedge clk); #1 inj_rise = 1;
    repeat (4) @(negedge clk);
    chk("s5_hold", rx_data, 8'hC3);

    // Scenario 6: divisor 2 versus 254.
    mosi_q.delete(); dv_half = 1;
    run_xfer(8'h96, 8'h69, low);
    chk("s6_rx_fast", rx_data, 8'h69);
    chk("s6_mosi_fast", mbyte(0), 8'h96);
    chk("s6_low_fast", low, 20);
    mosi_q.delete(); dv_half = 127;
    run_xfer(8'h96, 8'h69, low2);
    chk("s6_rx_slow", rx_data, 8'h69);
    chk("s6_mosi_slow", mbyte(0), 8'h96);
    chk("s6_low_slow", low2, 2036);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
